vc_input_unit: RTL and testbench

- Input port of a VC-based NoC router, generalised to VC_NUM virtual channels.
- Each VC has a circular flit FIFO and a packet FSM (IDLE/WAITING/ACTIVE), and raises an allocation request with its latched header.
- A round-robin arbiter picks one ACTIVE VC per cycle to drive the single registered output flit.
- Route computation and VC/switch allocation sit outside this block.

---
 rtl/vc_input_unit.sv | 270 +++++++++++++++++++++++++++
 tb/tb_vc_input_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_input_unit.sv
// -----------------------------------------------------------------------------
// vc_input_unit
// Input port of a virtual-channel NoC router. Each VC owns a circular flit
// FIFO and a packet FSM (IDLE -> WAITING -> ACTIVE). A VC in WAITING exposes
// its latched header and requests allocation; once granted it streams its
// flits out. A round-robin arbiter selects one eligible ACTIVE VC per cycle
// and its head flit is registered onto the single output.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset (drops all in-flight flits)
//   data_i       incoming flit, type code in the MSBs
//   wr_en_i      write strobe for data_i
//   vc_sel_i     target VC of data_i
//   rdy_o        per-VC not-full, from registered occupancy
//   alloc_req_o  per-VC allocation request (VC is WAITING)
//   header_o     latched header per VC, VC v at [v*FLIT_W +: FLIT_W]
//   alloc_gnt_i  per-VC allocation grant (only honoured in WAITING)
//   chan_rdy_i   per-VC downstream buffer space available
//   data_o       registered output flit
//   data_vld_o   data_o valid this cycle
//   vc_o         VC that produced data_o
//   err_o        sticky protocol-error flag
// -----------------------------------------------------------------------------
module vc_input_unit #(
  parameter int                   VC_NUM      = 4,
  parameter int                   VC_ID_W     = 2,
  parameter int                   VC_DEPTH_W  = 2,
  parameter int                   FLIT_DATA_W = 8,
  parameter int                   FLIT_ID_W   = 2,
  parameter logic [FLIT_ID_W-1:0] HEADER_ID   = 2'b10,
  parameter logic [FLIT_ID_W-1:0] BODY_ID     = 2'b00,
  parameter logic [FLIT_ID_W-1:0] TAIL_ID     = 2'b01,
  localparam int                  FLIT_W      = FLIT_ID_W + FLIT_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [FLIT_W-1:0]        data_i,
  input  logic                     wr_en_i,
  input  logic [VC_ID_W-1:0]       vc_sel_i,
  output logic [VC_NUM-1:0]        rdy_o,
  output logic [VC_NUM-1:0]        alloc_req_o,
  output logic [VC_NUM*FLIT_W-1:0] header_o,
  input  logic [VC_NUM-1:0]        alloc_gnt_i,
  input  logic [VC_NUM-1:0]        chan_rdy_i,
  output logic [FLIT_W-1:0]        data_o,
  output logic                     data_vld_o,
  output logic [VC_ID_W-1:0]       vc_o,
  output logic                     err_o
);

  // Occupancy value of a full FIFO: pointers carry one extra wrap bit.
  localparam logic [VC_DEPTH_W:0] FULL_OCC = {1'b1, {VC_DEPTH_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAITING = 2'b01,
    ST_ACTIVE  = 2'b10
  } state_e;

  logic [FLIT_W-1:0]        mem_q    [VC_NUM][2**VC_DEPTH_W];
  logic [VC_DEPTH_W:0]      wr_ptr_q [VC_NUM];
  logic [VC_DEPTH_W:0]      wr_ptr_d [VC_NUM];
  logic [VC_DEPTH_W:0]      rd_ptr_q [VC_NUM];
  logic [VC_DEPTH_W:0]      rd_ptr_d [VC_NUM];
  logic [FLIT_W-1:0]        head_s   [VC_NUM];
  state_e                   state_q  [VC_NUM];

  logic [VC_NUM-1:0]        rdy_q;
  logic [VC_NUM-1:0]        rdy_d;
  logic [VC_NUM-1:0]        empty_s;
  logic [VC_NUM-1:0]        push_s;
  logic [VC_NUM-1:0]        discard_s;
  logic [VC_NUM-1:0]        elig_s;
  logic [VC_NUM-1:0]        pop_arb_s;
  logic [VC_NUM-1:0]        pop_s;
  logic [VC_NUM-1:0]        tail_s;
  logic [VC_NUM-1:0]        hdr_err_s;
  logic                     wr_err_s;
  logic                     found_s;
  logic [VC_ID_W-1:0]       win_s;

  logic [VC_NUM*FLIT_W-1:0] header_q;
  logic [VC_NUM-1:0]        first_q;
  logic [VC_NUM-1:0]        alloc_req_q;
  logic                     err_q;
  logic [VC_ID_W-1:0]       rr_q;
  logic [FLIT_W-1:0]        data_q;
  logic [VC_ID_W-1:0]       vc_q;
  logic                     vld_q;

  function automatic logic [FLIT_ID_W-1:0] flit_type(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-1 -: FLIT_ID_W];
  endfunction

  // base and off are both below VC_NUM, so one subtraction is enough.
  function automatic int rr_wrap(input int base, input int off);
    return ((base + off) >= VC_NUM) ? (base + off - VC_NUM) : (base + off);
  endfunction

  // Per-VC FIFO status, write acceptance and IDLE-state discard decision.
  always_comb begin
    wr_err_s = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      head_s[v]    = mem_q[v][rd_ptr_q[v][VC_DEPTH_W-1:0]];
      empty_s[v]   = (wr_ptr_q[v] == rd_ptr_q[v]);
      // rdy_q reflects the occupancy at the start of the cycle, so a
      // concurrent pop never makes room for this cycle's write.
      push_s[v]    = wr_en_i && (int'(vc_sel_i) == v) && rdy_q[v];
      discard_s[v] = (state_q[v] == ST_IDLE) && !empty_s[v] &&
                     (flit_type(head_s[v]) != HEADER_ID);
      elig_s[v]    = (state_q[v] == ST_ACTIVE) && !empty_s[v] && chan_rdy_i[v];
    end
    // Out-of-range VC or full VC: the flit is dropped.
    if (wr_en_i) begin
      wr_err_s = ~(|push_s);
    end else begin
      wr_err_s = 1'b0;
    end
  end

  // Round-robin pick among eligible VCs, starting at rr_q.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (!found_s && elig_s[rr_wrap(int'(rr_q), i)]) begin
        found_s = 1'b1;
        win_s   = VC_ID_W'(rr_wrap(int'(rr_q), i));
      end else begin
        found_s = found_s;
      end
    end
  end

  // Classify the flit popped by the arbiter for each VC.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      pop_arb_s[v] = found_s && (int'(win_s) == v);
      tail_s[v]    = 1'b0;
      hdr_err_s[v] = 1'b0;
      if (pop_arb_s[v]) begin
        case (flit_type(head_s[v]))
          HEADER_ID: hdr_err_s[v] = !first_q[v];
          TAIL_ID:   tail_s[v]    = 1'b1;
          BODY_ID:   tail_s[v]    = 1'b0;
          default:   tail_s[v]    = 1'b0;
        endcase
      end else begin
        tail_s[v] = 1'b0;
      end
    end
    pop_s = pop_arb_s | discard_s;
  end

  // Next FIFO pointers and the not-full flag they imply.
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v] + {{VC_DEPTH_W{1'b0}}, push_s[v]};
      rd_ptr_d[v] = rd_ptr_q[v] + {{VC_DEPTH_W{1'b0}}, pop_s[v]};
      rdy_d[v]    = ((wr_ptr_d[v] - rd_ptr_d[v]) != FULL_OCC);
    end
  end

  // FIFO pointer and ready registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
      rdy_q <= '1;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
      end
      rdy_q <= rdy_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark it empty.
  always_ff @(posedge clk_i) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (push_s[v]) begin
        mem_q[v][wr_ptr_q[v][VC_DEPTH_W-1:0]] <= data_i;
      end
    end
  end

  // Per-VC packet FSM with registered header, request and first-flit flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v] <= ST_IDLE;
      end
      header_q    <= '0;
      first_q     <= '0;
      alloc_req_q <= '0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        case (state_q[v])
          ST_IDLE: begin
            // The header stays in the FIFO; it is forwarded once ACTIVE.
            if (!empty_s[v] && (flit_type(head_s[v]) == HEADER_ID)) begin
              header_q[v*FLIT_W +: FLIT_W] <= head_s[v];
              state_q[v]                   <= ST_WAITING;
              alloc_req_q[v]               <= 1'b1;
            end
          end
          ST_WAITING: begin
            if (alloc_gnt_i[v]) begin
              state_q[v]     <= ST_ACTIVE;
              alloc_req_q[v] <= 1'b0;
              first_q[v]     <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (pop_arb_s[v]) begin
              first_q[v] <= 1'b0;
              if (tail_s[v]) begin
                state_q[v] <= ST_IDLE;
              end
            end
          end
          default: begin
            state_q[v]     <= ST_IDLE;
            alloc_req_q[v] <= 1'b0;
            first_q[v]     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered output flit and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      vc_q   <= '0;
      vld_q  <= 1'b0;
      rr_q   <= '0;
    end else if (found_s) begin
      data_q <= head_s[win_s];
      vc_q   <= win_s;
      vld_q  <= 1'b1;
      rr_q   <= VC_ID_W'(rr_wrap(int'(win_s), 1));
    end else begin
      vld_q  <= 1'b0;
    end
  end

  // Sticky protocol-error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | wr_err_s | (|discard_s) | (|hdr_err_s);
    end
  end

  assign rdy_o       = rdy_q;
  assign alloc_req_o = alloc_req_q;
  assign header_o    = header_q;
  assign data_o      = data_q;
  assign data_vld_o  = vld_q;
  assign vc_o        = vc_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_vc_input_unit.sv
// -----------------------------------------------------------------------------
// tb_vc_input_unit
// Directed scenarios plus randomized traffic for vc_input_unit. A transaction
// model built from queues tracks every VC and predicts all outputs each cycle.
// -----------------------------------------------------------------------------
module tb_vc_input_unit;

  typedef logic [9:0]  flit_t;
  typedef logic [11:0] ent_t;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_ACT  = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [9:0]  data_i = '0;
  logic        wr_en_i = 1'b0;
  logic [1:0]  vc_sel_i = '0;
  logic [3:0]  rdy_o;
  logic [3:0]  alloc_req_o;
  logic [39:0] header_o;
  logic [3:0]  alloc_gnt_i = '0;
  logic [3:0]  chan_rdy_i = 4'hF;
  logic [9:0]  data_o;
  logic        data_vld_o;
  logic [1:0]  vc_o;
  logic        err_o;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  flit_t mq [4][$];
  int    ph [4];
  flit_t mhdr [4];
  bit    mfirst [4];
  int    mrr;
  flit_t mdata;
  bit    mvld;
  logic [1:0] mvc;
  bit    merr;

  ent_t out_log[$];
  ent_t exp_q[$];

  vc_input_unit dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .wr_en_i     (wr_en_i),
    .vc_sel_i    (vc_sel_i),
    .rdy_o       (rdy_o),
    .alloc_req_o (alloc_req_o),
    .header_o    (header_o),
    .alloc_gnt_i (alloc_gnt_i),
    .chan_rdy_i  (chan_rdy_i),
    .data_o      (data_o),
    .data_vld_o  (data_vld_o),
    .vc_o        (vc_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 4; v++) begin
      mq[v].delete();
      ph[v]     = M_IDLE;
      mhdr[v]   = '0;
      mfirst[v] = 1'b0;
    end
    mrr   = 0;
    mdata = '0;
    mvld  = 1'b0;
    mvc   = '0;
    merr  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit    do_push;
    bit    el [4];
    int    w;
    int    v;
    flit_t f;
    do_push = 1'b0;
    if (wr_en_i) begin
      if (mq[vc_sel_i].size() < 4) do_push = 1'b1;
      else merr = 1'b1;
    end
    for (int k = 0; k < 4; k++)
      el[k] = (ph[k] == M_ACT) && (mq[k].size() > 0) && chan_rdy_i[k];
    for (int k = 0; k < 4; k++) begin
      if (ph[k] == M_IDLE && mq[k].size() > 0) begin
        f = mq[k][0];
        if (f[9:8] == 2'b10) begin
          mhdr[k] = f;
          ph[k]   = M_WAIT;
        end else begin
          void'(mq[k].pop_front());
          merr = 1'b1;
        end
      end else if (ph[k] == M_WAIT && alloc_gnt_i[k]) begin
        ph[k]     = M_ACT;
        mfirst[k] = 1'b1;
      end
    end
    w = -1;
    for (int i = 0; i < 4; i++) begin
      v = (mrr + i) % 4;
      if (w < 0 && el[v]) w = v;
    end
    if (w >= 0) begin
      f     = mq[w].pop_front();
      mdata = f;
      mvc   = 2'(w);
      mvld  = 1'b1;
      if (f[9:8] == 2'b01) ph[w] = M_IDLE;
      if (f[9:8] == 2'b10 && !mfirst[w]) merr = 1'b1;
      mfirst[w] = 1'b0;
      mrr = (w + 1) % 4;
    end else begin
      mvld = 1'b0;
    end
    if (do_push) mq[vc_sel_i].push_back(data_i);
  endtask

  task automatic compare_all();
    logic [3:0]  er;
    logic [3:0]  eq;
    logic [39:0] eh;
    for (int v = 0; v < 4; v++) begin
      er[v] = (mq[v].size() < 4);
      eq[v] = (ph[v] == M_WAIT);
      eh[v*10 +: 10] = mhdr[v];
    end
    chk("vld", data_vld_o, mvld);
    chk("data", data_o, mdata);
    chk("vc", vc_o, mvc);
    chk("err", err_o, merr);
    chk("rdy", rdy_o, er);
    chk("req", alloc_req_o, eq);
    chk("hdr", header_o, eh);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    if (data_vld_o) out_log.push_back({vc_o, data_o});
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic put(input int vc, input flit_t f);
    wr_en_i  = 1'b1;
    vc_sel_i = vc[1:0];
    data_i   = f;
    tick();
    wr_en_i  = 1'b0;
  endtask

  task automatic ex(input int vc, input flit_t f);
    exp_q.push_back({vc[1:0], f});
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_count"}, out_log.size(), exp_q.size());
    foreach (exp_q[i])
      chk(tag, (i < out_log.size()) ? out_log[i] : 12'hFFF, exp_q[i]);
    exp_q.delete();
  endtask

  // Called at a negedge; reset outputs must drop without waiting for a clock.
  task automatic do_reset();
    rst_ni      = 1'b0;
    wr_en_i     = 1'b0;
    alloc_gnt_i = 4'h0;
    chan_rdy_i  = 4'hF;
    #1;
    chk("rst_vld", data_vld_o, 1'b0);
    chk("rst_rdy", rdy_o, 4'hF);
    chk("rst_req", alloc_req_o, 4'h0);
    model_reset();
    out_log.delete();
    exp_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    compare_all();
  endtask

  function automatic flit_t mk5(input int k);
    logic [7:0] pl;
    pl = 8'h50 + 8'(k);
    if (k == 0)      return {2'b10, pl};
    else if (k == 9) return {2'b01, pl};
    else             return {2'b00, pl};
  endfunction

  initial begin
    @(negedge clk_i);
    do_reset();

    // single packet on VC1
    put(1, 10'h20A);
    chk("t1_req_early", alloc_req_o[1], 1'b0);
    put(1, 10'h011);
    chk("t1_req_t2", alloc_req_o[1], 1'b1);
    alloc_gnt_i = 4'h2;
    put(1, 10'h122);
    alloc_gnt_i = 4'h0;
    chk("t1_vld_active", data_vld_o, 1'b0);
    idle(5);
    ex(1, 10'h20A); ex(1, 10'h011); ex(1, 10'h122);
    chk_log("t1_flit");
    chk("t1_hdr", header_o[19:10], 10'h20A);
    chk("t1_err", err_o, 1'b0);
    chk("t1_req_done", alloc_req_o, 4'h0);

    // round-robin between VC0 and VC2
    do_reset();
    put(0, 10'h201); put(2, 10'h2A1);
    put(0, 10'h002); put(2, 10'h0A2);
    put(0, 10'h103); put(2, 10'h1A3);
    chk("t2_req", alloc_req_o, 4'h5);
    alloc_gnt_i = 4'h5;
    tick();
    alloc_gnt_i = 4'h0;
    idle(8);
    ex(0, 10'h201); ex(2, 10'h2A1); ex(0, 10'h002);
    ex(2, 10'h0A2); ex(0, 10'h103); ex(2, 10'h1A3);
    chk_log("t2_rr");

    // fill VC3, overflow, then stall its channel mid-packet
    do_reset();
    put(3, 10'h2C0); put(3, 10'h0C1); put(3, 10'h0C2); put(3, 10'h1C3);
    chk("t3_full", rdy_o[3], 1'b0);
    chk("t3_err_pre", err_o, 1'b0);
    put(3, 10'h0C4);
    chk("t3_drop_err", err_o, 1'b1);
    alloc_gnt_i = 4'h8;
    tick();
    alloc_gnt_i = 4'h0;
    tick();
    chk("t3_first_out", data_vld_o, 1'b1);
    chan_rdy_i = 4'h7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stall", data_vld_o, 1'b0);
    end
    chan_rdy_i = 4'hF;
    idle(5);
    ex(3, 10'h2C0); ex(3, 10'h0C1); ex(3, 10'h0C2); ex(3, 10'h1C3);
    chk_log("t3_flit");

    // body flit arriving at an idle VC
    do_reset();
    put(0, 10'h033);
    idle(2);
    chk("t4_err", err_o, 1'b1);
    chk("t4_req", alloc_req_o[0], 1'b0);
    chk("t4_nout", out_log.size(), 0);

    // ten flits through a depth-4 FIFO
    do_reset();
    put(2, mk5(0));
    put(2, mk5(1));
    chk("t5_req", alloc_req_o[2], 1'b1);
    alloc_gnt_i = 4'h4;
    put(2, mk5(2));
    alloc_gnt_i = 4'h0;
    for (int k = 3; k < 10; k++) put(2, mk5(k));
    idle(6);
    for (int k = 0; k < 10; k++) ex(2, mk5(k));
    chk_log("t5_flit");
    chk("t5_err", err_o, 1'b0);

    // reset in the middle of an active packet
    do_reset();
    put(0, 10'h2E0); put(0, 10'h0E1); put(0, 10'h0E2); put(0, 10'h1E3);
    alloc_gnt_i = 4'h1;
    tick();
    alloc_gnt_i = 4'h0;
    tick();
    chk("t6_pre_vld", data_vld_o, 1'b1);
    do_reset();
    idle(4);
    chk("t6_quiet", out_log.size(), 0);
    chk("t6_err", err_o, 1'b0);
    chk("t6_rdy", rdy_o, 4'hF);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int   r;
      logic [1:0] ty;
      r = $urandom_range(0, 9);
      if (r < 2)      ty = 2'b10;
      else if (r < 7) ty = 2'b00;
      else if (r < 9) ty = 2'b01;
      else            ty = 2'b11;
      wr_en_i     = ($urandom_range(0, 9) < 6);
      vc_sel_i    = 2'($urandom_range(0, 3));
      data_i      = {ty, 8'($urandom)};
      alloc_gnt_i = 4'($urandom);
      for (int v = 0; v < 4; v++) chan_rdy_i[v] = ($urandom_range(0, 3) != 0);
      tick();
    end
    wr_en_i = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
